// File: rtl/axi_read_arbiter_pkg.sv
// Shared AXI read-arbiter definitions: bus widths, FSM states, master index encoding.
package axi_read_arbiter_pkg;

    localparam int unsigned AXI_ID_BITS   = 4;
    localparam int unsigned AXI_IDS_BITS  = AXI_ID_BITS + 4;
    localparam int unsigned AXI_ADDR_BITS = 32;
    localparam int unsigned AXI_DATA_BITS = 32;
    localparam int unsigned AXI_LEN_BITS  = 4;
    localparam int unsigned AXI_SIZE_BITS = 3;

    localparam logic [3:0] MIdx0 = 4'd0;
    localparam logic [3:0] MIdx1 = 4'd1;

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    typedef struct packed {
        logic [AXI_ID_BITS-1:0]   id;
        logic [AXI_ADDR_BITS-1:0] addr;
        logic [AXI_LEN_BITS-1:0]  len;
        logic [AXI_SIZE_BITS-1:0] size;
        logic [1:0]               burst;
    } ar_t;

    function automatic logic [3:0] master_idx(input logic g);
        return g ? MIdx1 : MIdx0;
    endfunction

endpackage

// File: rtl/axi_read_arbiter_rr_arb2.sv
// Stateless two-requester round-robin picker; the priority bit is owned by the parent.
module axi_read_arbiter_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       en,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = en & (|req);
        // On a tie the master that did not win last time goes first.
        if (&req) begin
            grant = ~last;
        end else begin
            grant = req[1];
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Two-master to one-slave AXI read arbiter: round-robin AR grant, registered address
// phase, R burst routed back to the granted master until RLast.
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AXI_ID_BITS-1:0]   M0_ARID,
    input  logic [AXI_ADDR_BITS-1:0] M0_ARAddr,
    input  logic [AXI_LEN_BITS-1:0]  M0_ARLen,
    input  logic [AXI_SIZE_BITS-1:0] M0_ARSize,
    input  logic [1:0]               M0_ARBurst,
    input  logic                     M0_ARValid,
    output logic                     M0_ARReady,
    output logic [AXI_ID_BITS-1:0]   M0_RID,
    output logic [AXI_DATA_BITS-1:0] M0_RData,
    output logic [1:0]               M0_RResp,
    output logic                     M0_RLast,
    output logic                     M0_RValid,
    input  logic                     M0_RReady,
    input  logic [AXI_ID_BITS-1:0]   M1_ARID,
    input  logic [AXI_ADDR_BITS-1:0] M1_ARAddr,
    input  logic [AXI_LEN_BITS-1:0]  M1_ARLen,
    input  logic [AXI_SIZE_BITS-1:0] M1_ARSize,
    input  logic [1:0]               M1_ARBurst,
    input  logic                     M1_ARValid,
    output logic                     M1_ARReady,
    output logic [AXI_ID_BITS-1:0]   M1_RID,
    output logic [AXI_DATA_BITS-1:0] M1_RData,
    output logic [1:0]               M1_RResp,
    output logic                     M1_RLast,
    output logic                     M1_RValid,
    input  logic                     M1_RReady,
    output logic [AXI_IDS_BITS-1:0]  S_ARID,
    output logic [AXI_ADDR_BITS-1:0] S_ARAddr,
    output logic [AXI_LEN_BITS-1:0]  S_ARLen,
    output logic [AXI_SIZE_BITS-1:0] S_ARSize,
    output logic [1:0]               S_ARBurst,
    output logic                     S_ARValid,
    input  logic                     S_ARReady,
    input  logic [AXI_IDS_BITS-1:0]  S_RID,
    input  logic [AXI_DATA_BITS-1:0] S_RData,
    input  logic [1:0]               S_RResp,
    input  logic                     S_RLast,
    input  logic                     S_RValid,
    output logic                     S_RReady
);

    state_e state_q;
    logic   last_q;
    logic   grant_q;
    ar_t    ar_q;
    ar_t    m0_ar, m1_ar;
    logic   arb_grant, arb_valid;
    logic   unused_rid;

    assign m0_ar = '{id: M0_ARID, addr: M0_ARAddr, len: M0_ARLen, size: M0_ARSize,
                     burst: M0_ARBurst};
    assign m1_ar = '{id: M1_ARID, addr: M1_ARAddr, len: M1_ARLen, size: M1_ARSize,
                     burst: M1_ARBurst};

    // Routing relies on the registered grant, so the slave's index nibble is ignored.
    assign unused_rid = ^S_RID[AXI_IDS_BITS-1:AXI_ID_BITS];

    axi_read_arbiter_rr_arb2 u_rr_arb2 (
        .req   ({M1_ARValid, M0_ARValid}),
        .last  (last_q),
        .en    ((state_q == StIdle) && rst),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            grant_q <= 1'b0;
            ar_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (arb_valid) begin
                        ar_q    <= arb_grant ? m1_ar : m0_ar;
                        grant_q <= arb_grant;
                        last_q  <= arb_grant;
                        state_q <= StAddr;
                    end
                end
                StAddr: begin
                    if (S_ARReady) begin
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (S_RValid && S_RReady && S_RLast) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        M0_ARReady = arb_valid & ~arb_grant;
        M1_ARReady = arb_valid & arb_grant;

        S_ARID    = {master_idx(grant_q), ar_q.id};
        S_ARAddr  = ar_q.addr;
        S_ARLen   = ar_q.len;
        S_ARSize  = ar_q.size;
        S_ARBurst = ar_q.burst;
        S_ARValid = (state_q == StAddr);

        M0_RID    = '0;
        M0_RData  = '0;
        M0_RResp  = '0;
        M0_RLast  = 1'b0;
        M0_RValid = 1'b0;
        M1_RID    = '0;
        M1_RData  = '0;
        M1_RResp  = '0;
        M1_RLast  = 1'b0;
        M1_RValid = 1'b0;
        S_RReady  = 1'b0;

        if (state_q == StData) begin
            if (grant_q) begin
                M1_RID    = S_RID[AXI_ID_BITS-1:0];
                M1_RData  = S_RData;
                M1_RResp  = S_RResp;
                M1_RLast  = S_RLast;
                M1_RValid = S_RValid;
                S_RReady  = M1_RReady;
            end else begin
                M0_RID    = S_RID[AXI_ID_BITS-1:0];
                M0_RData  = S_RData;
                M0_RResp  = S_RResp;
                M0_RLast  = S_RLast;
                M0_RValid = S_RValid;
                S_RReady  = M0_RReady;
            end
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: directed scenarios plus randomized transactions against a
// transaction-level round-robin model; the bench also plays the slave.
module tb_axi_read_arbiter;
    import axi_read_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [3:0]  ar_id    [2];
    logic [31:0] ar_addr  [2];
    logic [3:0]  ar_len   [2];
    logic [2:0]  ar_size  [2];
    logic [1:0]  ar_burst [2];
    logic [1:0]  ar_valid = 2'b00;
    logic [1:0]  r_ready  = 2'b00;
    wire  [1:0]  ar_ready, r_valid, r_last;
    wire  [3:0]  r_id   [2];
    wire  [31:0] r_data [2];
    wire  [1:0]  r_resp [2];

    wire  [7:0]  s_arid;
    wire  [31:0] s_araddr;
    wire  [3:0]  s_arlen;
    wire  [2:0]  s_arsize;
    wire  [1:0]  s_arburst;
    wire         s_arvalid, s_rready;
    logic        s_arready = 1'b0;
    logic [7:0]  s_rid     = '0;
    logic [31:0] s_rdata   = '0;
    logic [1:0]  s_rresp   = '0;
    logic        s_rlast   = 1'b0;
    logic        s_rvalid  = 1'b0;

    wire [132:0] all_out = {ar_ready, r_valid, r_last, s_arvalid, s_rready, s_arid, s_araddr,
                            s_arlen, s_arsize, s_arburst, r_data[0], r_data[1], r_id[0],
                            r_id[1], r_resp[0], r_resp[1]};

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: round-robin priority bit, masters still waiting, last granted master.
    bit       exp_last = 1'b1;
    bit [1:0] pending  = 2'b00;
    int       last_g   = -1;

    axi_read_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .M0_ARID    (ar_id[0]),
        .M0_ARAddr  (ar_addr[0]),
        .M0_ARLen   (ar_len[0]),
        .M0_ARSize  (ar_size[0]),
        .M0_ARBurst (ar_burst[0]),
        .M0_ARValid (ar_valid[0]),
        .M0_ARReady (ar_ready[0]),
        .M0_RID     (r_id[0]),
        .M0_RData   (r_data[0]),
        .M0_RResp   (r_resp[0]),
        .M0_RLast   (r_last[0]),
        .M0_RValid  (r_valid[0]),
        .M0_RReady  (r_ready[0]),
        .M1_ARID    (ar_id[1]),
        .M1_ARAddr  (ar_addr[1]),
        .M1_ARLen   (ar_len[1]),
        .M1_ARSize  (ar_size[1]),
        .M1_ARBurst (ar_burst[1]),
        .M1_ARValid (ar_valid[1]),
        .M1_ARReady (ar_ready[1]),
        .M1_RID     (r_id[1]),
        .M1_RData   (r_data[1]),
        .M1_RResp   (r_resp[1]),
        .M1_RLast   (r_last[1]),
        .M1_RValid  (r_valid[1]),
        .M1_RReady  (r_ready[1]),
        .S_ARID     (s_arid),
        .S_ARAddr   (s_araddr),
        .S_ARLen    (s_arlen),
        .S_ARSize   (s_arsize),
        .S_ARBurst  (s_arburst),
        .S_ARValid  (s_arvalid),
        .S_ARReady  (s_arready),
        .S_RID      (s_rid),
        .S_RData    (s_rdata),
        .S_RResp    (s_rresp),
        .S_RLast    (s_rlast),
        .S_RValid   (s_rvalid),
        .S_RReady   (s_rready)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish by 400us, required finish");
        $fatal(1);
    end

    task automatic rand_ar(input int m);
        ar_id[m]    = 4'($urandom);
        ar_addr[m]  = $urandom;
        ar_len[m]   = 4'($urandom);
        ar_size[m]  = 3'($urandom_range(0, 2));
        ar_burst[m] = 2'($urandom_range(0, 2));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ar_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_last = 1'b1;
        pending = 2'b00;
    endtask

    // One full transaction: arbitration, address phase, R burst. Entered and left at a
    // negedge with the arbiter idle.
    task automatic run_txn(input logic [1:0] new_req, input int ar_delay, input int len_force,
                           input bit late_req, input bit fixed, input bit gated);
        logic [1:0]  req, exp_ar, exp_rv;
        logic [3:0]  e_id, e_len;
        logic [31:0] e_addr;
        logic [2:0]  e_size;
        logic [1:0]  e_burst;
        logic        sv, rr;
        logic [31:0] exp_q[$];
        int g, o, beats, beat, cyc, got;

        req = pending | new_req;
        if (req == 2'b00) req = 2'b01;
        for (int m = 0; m < 2; m++) begin
            if (req[m] && !pending[m]) begin
                rand_ar(m);
                if (len_force >= 0) ar_len[m] = len_force[3:0];
                if (fixed) begin
                    ar_addr[m] = 32'h0000_0100;
                    ar_len[m]  = 4'd0;
                end
            end
        end
        ar_valid = req;
        r_ready = 2'b11;
        g = (req == 2'b11) ? (exp_last ? 0 : 1) : (req[1] ? 1 : 0);
        o = 1 - g;
        exp_ar = 2'b00;
        exp_ar[g] = 1'b1;
        #1;
        n_checks++;
        if (ar_ready !== exp_ar || s_arvalid !== 1'b0)
            $display("FAIL grant: got arready=%b arvalid=%b, required arready=%b arvalid=0",
                     ar_ready, s_arvalid, exp_ar);
        else n_pass++;

        exp_last = g[0];
        last_g = g;
        pending = req & ~exp_ar;
        e_id = ar_id[g]; e_addr = ar_addr[g]; e_len = ar_len[g];
        e_size = ar_size[g]; e_burst = ar_burst[g];

        @(negedge clk);
        ar_valid[g] = 1'b0;
        rand_ar(g);
        for (int i = 0; i <= ar_delay; i++) begin
            s_arready = (i == ar_delay);
            #1;
            n_checks++;
            if ({s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst}
                    !== {1'b1, 4'(g), e_id, e_addr, e_len, e_size, e_burst})
                $display("FAIL s_ar: got %h, required %h",
                         {s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst},
                         {1'b1, 4'(g), e_id, e_addr, e_len, e_size, e_burst});
            else n_pass++;
            n_checks++;
            if ({ar_ready, r_valid, s_rready} !== 5'b0)
                $display("FAIL addr_quiet: got %b, required 0", {ar_ready, r_valid, s_rready});
            else n_pass++;
            @(negedge clk);
        end
        s_arready = 1'b0;

        beats = int'(e_len) + 1;
        for (int b = 0; b < beats; b++) exp_q.push_back(fixed ? 32'hDEAD_BEEF : $urandom);
        beat = 0; cyc = 0; got = 0;
        while (beat < beats) begin
            if (gated) begin
                sv = (cyc % 2 == 0);
                rr = (cyc >= 2);
            end else begin
                sv = ($urandom_range(0, 2) != 0);
                rr = ($urandom_range(0, 2) != 0);
            end
            if (late_req && cyc == 1 && !pending[o]) begin
                rand_ar(o);
                ar_valid[o] = 1'b1;
                pending[o] = 1'b1;
            end
            s_rvalid = sv;
            s_rdata = exp_q[beat];
            s_rresp = 2'($urandom);
            s_rid = 8'($urandom);
            s_rlast = (beat == beats - 1);
            r_ready = 2'($urandom);
            r_ready[g] = rr;
            exp_rv = 2'b00;
            exp_rv[g] = sv;
            #1;
            n_checks++;
            if (r_valid !== exp_rv || s_rready !== rr || ar_ready !== 2'b00)
                $display("FAIL r_ctrl: got rvalid=%b srready=%b arready=%b, required %b %b 00",
                         r_valid, s_rready, ar_ready, exp_rv, rr);
            else n_pass++;
            n_checks++;
            if ({r_data[o], r_id[o], r_resp[o], r_last[o]} !== 39'b0)
                $display("FAIL r_other: got %h, required 0",
                         {r_data[o], r_id[o], r_resp[o], r_last[o]});
            else n_pass++;
            if (sv) begin
                n_checks++;
                if ({r_data[g], r_id[g], r_resp[g], r_last[g]}
                        !== {exp_q[beat], s_rid[3:0], s_rresp, beat == beats - 1})
                    $display("FAIL r_beat%0d: got %h, required %h", beat,
                             {r_data[g], r_id[g], r_resp[g], r_last[g]},
                             {exp_q[beat], s_rid[3:0], s_rresp, beat == beats - 1});
                else n_pass++;
            end
            if (r_valid[g] && r_ready[g]) got++;
            if (sv && rr) beat++;
            @(negedge clk);
            cyc++;
            if (cyc > 400) begin
                n_checks++;
                $display("FAIL r_timeout: got %0d beats, required %0d", beat, beats);
                break;
            end
        end
        s_rvalid = 1'b0;
        s_rlast = 1'b0;
        n_checks++;
        if (got !== beats) $display("FAIL beat_count: got %0d, required %0d", got, beats);
        else n_pass++;
    endtask

    task automatic test_reset();
        rand_ar(0);
        rand_ar(1);
        rst = 1'b0;
        ar_valid = 2'b11;
        s_arready = 1'b1;
        s_rvalid = 1'b1;
        s_rdata = 32'hFFFF_FFFF;
        r_ready = 2'b11;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (all_out !== '0) $display("FAIL reset_outputs: got %h, required 0", all_out);
        else n_pass++;
        ar_valid = 2'b00;
        s_arready = 1'b0;
        s_rvalid = 1'b0;
        rst = 1'b1;
        exp_last = 1'b1;
        pending = 2'b00;
    endtask

    task automatic test_single();
        run_txn(2'b01, 0, 0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (last_g !== 0) $display("FAIL single_grant: got M%0d, required M0", last_g);
        else n_pass++;
    endtask

    task automatic test_alternate();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            run_txn(2'b11, 0, 0, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (last_g !== k % 2)
                $display("FAIL alternate%0d: got M%0d, required M%0d", k, last_g, k % 2);
            else n_pass++;
        end
    endtask

    task automatic test_ar_backpressure();
        run_txn(2'b01, 5, -1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_burst();
        run_txn(2'b10, 1, 3, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (last_g !== 1) $display("FAIL burst_grant: got M%0d, required M1", last_g);
        else n_pass++;
        run_txn(2'b00, 0, -1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (last_g !== 0) $display("FAIL late_grant: got M%0d, required M0", last_g);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++)
            run_txn(2'($urandom_range(0, 3)), $urandom_range(0, 3), -1,
                    1'($urandom_range(0, 1)), 1'b0, 1'b0);
        while (pending != 2'b00) run_txn(2'b00, 0, -1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midburst();
        rand_ar(1);
        ar_len[1] = 4'd3;
        ar_valid = 2'b10;
        #1;
        n_checks++;
        if (ar_ready !== 2'b10) $display("FAIL rm_grant: got %b, required 10", ar_ready);
        else n_pass++;
        @(negedge clk);
        ar_valid = 2'b00;
        s_arready = 1'b1;
        @(negedge clk);
        s_arready = 1'b0;
        s_rvalid = 1'b1;
        s_rlast = 1'b0;
        s_rdata = $urandom;
        r_ready = 2'b11;
        @(negedge clk);
        s_rdata = $urandom;
        rst = 1'b0;
        rand_ar(0);
        rand_ar(1);
        ar_valid = 2'b11;
        #1;
        n_checks++;
        if (r_valid !== 2'b10) $display("FAIL rm_beat2: got %b, required 10", r_valid);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (all_out !== '0) $display("FAIL rm_outputs: got %h, required 0", all_out);
        else n_pass++;
        rst = 1'b1;
        s_rvalid = 1'b0;
        exp_last = 1'b1;
        pending = 2'b11;
        run_txn(2'b00, 0, -1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (last_g !== 0) $display("FAIL rm_first: got M%0d, required M0", last_g);
        else n_pass++;
        run_txn(2'b00, 0, -1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int m = 0; m < 2; m++) rand_ar(m);
        test_reset();
        test_single();
        test_alternate();
        test_ar_backpressure();
        test_burst();
        test_random();
        test_reset_midburst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
